// File: rtl/trdos_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trdos_pkg
//  Description : Shared constants, NMI state type and port-match helper for
//                the TR-DOS (Beta Disk) port decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package trdos_pkg;

    localparam logic [7:0]  PORT_FF            = 8'hFF;
    localparam logic [4:0]  PORT_LSB           = 5'h1F;
    localparam logic [15:0] NMI_VEC            = 16'h0066;
    localparam logic [7:0]  DEFAULT_ENTRY_PAGE = 8'h3D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } nmi_state_t;

    // FDC register ports #1F/#3F/#5F/#7F: bit 7 clear, low five bits all ones.
    function automatic logic is_fdc_port(input logic [7:0] port);
        return (port[7] == 1'b0) && (port[4:0] == PORT_LSB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/trdos_port_decoder_m1_fetch_detect.sv
`default_nettype none
// ============================================================================
//  Module      : m1_fetch_detect
//  Description : Produces a single-clock strobe at the start of each Z80
//                opcode fetch (M1 with MREQ). The strobe is re-armed only
//                when m1_n returns high, so a long M1 yields one pulse.
//  Ports       : clk, reset (sync, active-high), m1_n, mreq_n -> fetch_stb
//  Revision    : 1.0  initial release
// ============================================================================
module m1_fetch_detect (
    input  logic clk,
    input  logic reset,
    input  logic m1_n,
    input  logic mreq_n,
    output logic fetch_stb
);

    logic armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            armed <= 1'b1;
        end else if (m1_n) begin
            armed <= 1'b1;
        end else if (!mreq_n) begin
            armed <= 1'b0;
        end
    end

    assign fetch_stb = armed & ~m1_n & ~mreq_n;

endmodule
`default_nettype wire

// File: rtl/trdos_port_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : trdos_port_decoder
//  Description : Tracks TR-DOS active state from Z80 opcode fetches, drives
//                DOS ROM paging and decodes the WD1793 chip selects
//                (cs_n for #1F/#3F/#5F/#7F, csff_n for #FF).
//  Config      : TRDOS_NMI_EN - when defined, builds the magic-button NMI
//                logic (2-FF synchroniser + IDLE/REQ/HOLD FSM); otherwise
//                magic_btn is ignored and nmi_n is held at 1.
//  Ports       : clk, reset (sync, active-high), a[15:0], m1_n, mreq_n,
//                iorq_n, rd_n, wr_n, rom48_sel, dos_en, magic_btn ->
//                cs_n, csff_n, dos_active, rom_dos_sel, nmi_n
//  Revision    : 1.0  initial release
// ============================================================================
module trdos_port_decoder
    import trdos_pkg::*;
#(
    parameter bit         DOS_BOOT   = 1'b0,
    parameter logic [7:0] ENTRY_PAGE = DEFAULT_ENTRY_PAGE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rom48_sel,
    input  logic        dos_en,
    input  logic        magic_btn,
    output logic        cs_n,
    output logic        csff_n,
    output logic        dos_active,
    output logic        rom_dos_sel,
    output logic        nmi_n
);

    logic fetch_stb;
    logic entry_hit;
    logic exit_hit;
    logic nmi_entry;
    logic io_cyc;

    m1_fetch_detect u_fetch (
        .clk       (clk),
        .reset     (reset),
        .m1_n      (m1_n),
        .mreq_n    (mreq_n),
        .fetch_stb (fetch_stb)
    );

    assign entry_hit = fetch_stb & (a[15:8] == ENTRY_PAGE) & rom48_sel & dos_en;
    assign exit_hit  = fetch_stb & (a[15:14] != 2'b00);

`ifdef TRDOS_NMI_EN
    logic       btn_meta;
    logic       btn_sync;
    logic       btn_prev;
    nmi_state_t nmi_state;

    // Vector fetch while the NMI is pending is what actually enters DOS.
    assign nmi_entry = (nmi_state == REQ) & fetch_stb & (a == NMI_VEC) & dos_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            btn_prev  <= 1'b0;
            nmi_state <= IDLE;
            nmi_n     <= 1'b1;
        end else begin
            btn_meta <= magic_btn;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
            if (!dos_en) begin
                nmi_state <= IDLE;
                nmi_n     <= 1'b1;
            end else begin
                case (nmi_state)
                    IDLE: begin
                        if (btn_sync && !btn_prev) begin
                            nmi_state <= REQ;
                            nmi_n     <= 1'b0;
                        end
                    end
                    REQ: begin
                        if (nmi_entry) begin
                            nmi_state <= HOLD;
                            nmi_n     <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (!btn_sync) begin
                            nmi_state <= IDLE;
                        end
                    end
                    default: begin
                        nmi_state <= IDLE;
                        nmi_n     <= 1'b1;
                    end
                endcase
            end
        end
    end
`else
    logic unused_magic_btn;
    assign unused_magic_btn = magic_btn;
    assign nmi_entry        = 1'b0;
    assign nmi_n            = 1'b1;
`endif

    // Disable beats entry; entry beats exit (entry page lies below 4000h anyway).
    always_ff @(posedge clk) begin
        if (reset) begin
            dos_active <= DOS_BOOT;
        end else if (!dos_en) begin
            dos_active <= 1'b0;
        end else if (entry_hit || nmi_entry) begin
            dos_active <= 1'b1;
        end else if (exit_hit) begin
            dos_active <= 1'b0;
        end
    end

    // The combinational entry term lets the entry fetch itself read DOS ROM.
    assign rom_dos_sel = dos_active | entry_hit;

    // INTA (m1_n low with iorq_n low) is excluded by the m1_n term.
    assign io_cyc = ~iorq_n & m1_n & ~(rd_n & wr_n);
    assign cs_n   = ~(dos_active & io_cyc & is_fdc_port(a[7:0]));
    assign csff_n = ~(dos_active & io_cyc & (a[7:0] == PORT_FF));

endmodule
`default_nettype wire

// File: tb/tb_trdos_port_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trdos_port_decoder
//  Description : Self-checking bench for trdos_port_decoder: directed vector
//                table, randomized bus traffic against a behavioural model,
//                and hand-written NMI / reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trdos_port_decoder;

    localparam int K_IDLE  = 0;
    localparam int K_FETCH = 1;
    localparam int K_IN    = 2;
    localparam int K_OUT   = 3;
    localparam int K_INTA  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n;
    logic        rom48_sel, dos_en, magic_btn;
    logic        cs_n, csff_n, dos_active, rom_dos_sel, nmi_n;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    trdos_port_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .m1_n        (m1_n),
        .mreq_n      (mreq_n),
        .iorq_n      (iorq_n),
        .rd_n        (rd_n),
        .wr_n        (wr_n),
        .rom48_sel   (rom48_sel),
        .dos_en      (dos_en),
        .magic_btn   (magic_btn),
        .cs_n        (cs_n),
        .csff_n      (csff_n),
        .dos_active  (dos_active),
        .rom_dos_sel (rom_dos_sel),
        .nmi_n       (nmi_n)
    );

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic        rom48;
        logic        en;
        logic        e_cs_n;
        logic        e_csff_n;
        logic        e_rom;
        logic        e_dos;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input int k, input logic [15:0] addr);
        a = addr; m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        case (k)
            K_FETCH: begin m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; end
            K_IN:    begin iorq_n = 1'b0; rd_n = 1'b0; end
            K_OUT:   begin iorq_n = 1'b0; wr_n = 1'b0; end
            K_INTA:  begin m1_n = 1'b0; iorq_n = 1'b0; end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1; bus(K_IDLE, 16'h0000); rom48_sel = 1'b1; dos_en = 1'b1; magic_btn = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    function automatic vec_t v(int k, logic [15:0] ad, logic r48, logic en,
                               logic cs, logic ff, logic rom, logic dos);
        vec_t x;
        x.kind = k; x.addr = ad; x.rom48 = r48; x.en = en;
        x.e_cs_n = cs; x.e_csff_n = ff; x.e_rom = rom; x.e_dos = dos;
        return x;
    endfunction

    // ---------------- behavioural reference model ----------------
    logic m_dos;
    logic m_seen;   // a strobe already happened during the current M1 low

    function automatic logic fdc_reg_port(logic [7:0] p);
        return (p == 8'h1F) || (p == 8'h3F) || (p == 8'h5F) || (p == 8'h7F);
    endfunction

    initial begin
        bit ok;
        logic [31:0] r;
        logic [7:0] ports [5];
        logic stb, entry, io;

        ports = '{8'h1F, 8'h3F, 8'h5F, 8'h7F, 8'hFF};

        // ---------------- reset state ----------------
        reset = 1'b1; bus(K_IDLE, 16'h0000); rom48_sel = 1'b1; dos_en = 1'b1; magic_btn = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("reset_cs_n", cs_n, 1'b1);
        chk("reset_csff_n", csff_n, 1'b1);
        chk("reset_dos", dos_active, 1'b0);
        chk("reset_nmi_n", nmi_n, 1'b1);
        chk("reset_rom", rom_dos_sel, 1'b0);
        tick();
        reset = 1'b0;

        // ---------------- directed table ----------------
        //          kind     addr      r48 en  cs ff rom dos
        tbl.push_back(v(K_IDLE,  16'h0000, 1, 1, 1, 1, 0, 0));
        tbl.push_back(v(K_FETCH, 16'h3D2F, 1, 1, 1, 1, 1, 0));
        tbl.push_back(v(K_FETCH, 16'h3D2F, 1, 1, 1, 1, 1, 1));
        tbl.push_back(v(K_IDLE,  16'h0000, 1, 1, 1, 1, 1, 1));
        tbl.push_back(v(K_IN,    16'h001F, 1, 1, 0, 1, 1, 1));
        tbl.push_back(v(K_IN,    16'hFE7F, 1, 1, 0, 1, 1, 1));
        tbl.push_back(v(K_IN,    16'h00FF, 1, 1, 1, 0, 1, 1));
        tbl.push_back(v(K_IN,    16'h009F, 1, 1, 1, 1, 1, 1));
        tbl.push_back(v(K_OUT,   16'h003F, 1, 1, 0, 1, 1, 1));
        tbl.push_back(v(K_OUT,   16'h005F, 1, 1, 0, 1, 1, 1));
        tbl.push_back(v(K_INTA,  16'h00FF, 1, 1, 1, 1, 1, 1));
        tbl.push_back(v(K_IDLE,  16'h0000, 1, 1, 1, 1, 1, 1));
        tbl.push_back(v(K_FETCH, 16'h0100, 1, 1, 1, 1, 1, 1));
        tbl.push_back(v(K_IDLE,  16'h0000, 1, 1, 1, 1, 1, 1));
        tbl.push_back(v(K_FETCH, 16'h5CC2, 1, 1, 1, 1, 1, 1));
        tbl.push_back(v(K_FETCH, 16'h5CC2, 1, 1, 1, 1, 0, 0));
        tbl.push_back(v(K_IDLE,  16'h0000, 1, 1, 1, 1, 0, 0));
        tbl.push_back(v(K_IN,    16'h001F, 1, 1, 1, 1, 0, 0));
        tbl.push_back(v(K_IN,    16'h00FF, 1, 1, 1, 1, 0, 0));
        tbl.push_back(v(K_FETCH, 16'h3D00, 0, 1, 1, 1, 0, 0));
        tbl.push_back(v(K_FETCH, 16'h3D00, 0, 1, 1, 1, 0, 0));
        tbl.push_back(v(K_IDLE,  16'h0000, 1, 1, 1, 1, 0, 0));
        tbl.push_back(v(K_FETCH, 16'h3D00, 1, 1, 1, 1, 1, 0));
        // m1_n held low six clocks: a second strobe at 8000 would exit DOS
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(K_FETCH, 16'h8000, 1, 1, 1, 1, 1, 1));
        tbl.push_back(v(K_IDLE,  16'h0000, 1, 1, 1, 1, 1, 1));
        // dos_en drop in the middle of an I/O cycle
        tbl.push_back(v(K_IN,    16'h001F, 1, 1, 0, 1, 1, 1));
        tbl.push_back(v(K_IN,    16'h001F, 1, 0, 0, 1, 1, 1));
        tbl.push_back(v(K_IN,    16'h001F, 1, 0, 1, 1, 0, 0));
        tbl.push_back(v(K_FETCH, 16'h3D00, 1, 0, 1, 1, 0, 0));
        tbl.push_back(v(K_FETCH, 16'h3D00, 1, 0, 1, 1, 0, 0));
        tbl.push_back(v(K_IDLE,  16'h0000, 1, 1, 1, 1, 0, 0));

        foreach (tbl[i]) begin
            bus(tbl[i].kind, tbl[i].addr);
            rom48_sel = tbl[i].rom48;
            dos_en    = tbl[i].en;
            @(negedge clk);
            chk($sformatf("row%0d_cs_n", i), cs_n, tbl[i].e_cs_n);
            chk($sformatf("row%0d_csff_n", i), csff_n, tbl[i].e_csff_n);
            chk($sformatf("row%0d_rom", i), rom_dos_sel, tbl[i].e_rom);
            chk($sformatf("row%0d_dos", i), dos_active, tbl[i].e_dos);
            chk($sformatf("row%0d_nmi_n", i), nmi_n, 1'b1);
            tick();
        end

        // ---------------- randomized traffic vs model ----------------
        do_reset();
        m_dos = 1'b0; m_seen = 1'b0;
        for (int n = 0; n < 600; n++) begin
            r = $urandom;
            case ($urandom_range(0, 5))
                0: a = {8'h3D, r[7:0]};
                1: a = 16'h0066;
                2: a = {2'b01 + {1'b0, r[16]}, r[13:0]};
                3: a = {2'b00, r[13:0]};
                4: a = {r[15:8], ports[$urandom_range(0, 4)]};
                default: a = r[15:0];
            endcase
            r = $urandom;
            m1_n = r[0]; mreq_n = r[1]; iorq_n = r[2]; rd_n = r[3]; wr_n = r[4];
            rom48_sel = (r[7:5] != 3'd0);
            dos_en    = (r[11:8] != 4'd0);
            reset     = (r[17:12] == 6'd0);
`ifndef TRDOS_NMI_EN
            magic_btn = r[18];
`endif
            stb   = !m1_n && !mreq_n && !m_seen;
            entry = stb && (a[15:8] == 8'h3D) && rom48_sel && dos_en;
            io    = !iorq_n && m1_n && !(rd_n && wr_n);
            @(negedge clk);
            chk("rnd_cs_n", cs_n, !(m_dos && io && fdc_reg_port(a[7:0])));
            chk("rnd_csff_n", csff_n, !(m_dos && io && a[7:0] == 8'hFF));
            chk("rnd_rom", rom_dos_sel, m_dos || entry);
            chk("rnd_dos", dos_active, m_dos);
            chk("rnd_nmi_n", nmi_n, 1'b1);
            if (reset) begin
                m_dos = 1'b0; m_seen = 1'b0;
            end else begin
                if (!dos_en) m_dos = 1'b0;
                else if (entry) m_dos = 1'b1;
                else if (stb && a >= 16'h4000) m_dos = 1'b0;
                m_seen = m1_n ? 1'b0 : (m_seen || !mreq_n);
            end
            tick();
        end
        reset = 1'b0;
        magic_btn = 1'b0;

`ifdef TRDOS_NMI_EN
        // ---------------- NMI sequence ----------------
        do_reset();
        magic_btn = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!nmi_n) begin ok = 1'b1; break; end
            tick();
        end
        if (ok) tick();
        chk("nmi_req", ok, 1'b1);
        // bounce inside REQ must not disturb the pending request
        magic_btn = 1'b0; tick(); tick(); tick();
        magic_btn = 1'b1; tick(); tick(); tick();
        @(negedge clk);
        chk("nmi_req_hold", nmi_n, 1'b0);
        chk("nmi_req_dos", dos_active, 1'b0);
        tick();
        bus(K_FETCH, 16'h0066);
        tick();
        bus(K_IDLE, 16'h0000);
        @(negedge clk);
        chk("nmi_vec_dos", dos_active, 1'b1);
        chk("nmi_vec_nmi_n", nmi_n, 1'b1);
        tick();
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!nmi_n) ok = 1'b0;
            tick();
        end
        chk("nmi_held_no_renmi", ok, 1'b1);
        magic_btn = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        magic_btn = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!nmi_n) begin ok = 1'b1; break; end
            tick();
        end
        if (ok) tick();
        chk("nmi_second_press", ok, 1'b1);
        dos_en = 1'b0;
        tick();
        @(negedge clk);
        chk("nmi_dis_nmi_n", nmi_n, 1'b1);
        tick();
        dos_en = 1'b1;
        magic_btn = 1'b0;
        for (int i = 0; i < 4; i++) tick();
`endif

        // ---------------- reset while DOS active (and NMI pending) ----------------
        do_reset();
        bus(K_FETCH, 16'h3D00);
        tick();
        bus(K_IDLE, 16'h0000);
        tick();
`ifdef TRDOS_NMI_EN
        magic_btn = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!nmi_n) begin ok = 1'b1; break; end
            tick();
        end
        if (ok) tick();
        chk("rst_req_nmi", ok, 1'b1);
`endif
        bus(K_IN, 16'h001F);
        @(negedge clk);
        chk("rst_pre_cs_n", cs_n, 1'b0);
        chk("rst_pre_dos", dos_active, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_csff_n", csff_n, 1'b1);
        chk("rst_dos", dos_active, 1'b0);
        chk("rst_nmi_n", nmi_n, 1'b1);
        bus(K_IN, 16'h00FF);
        #1;
        chk("rst_csff_after", csff_n, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
